// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I inter-stage pipeline registers:
// FSM encoding, control-bundle field offsets and default widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 101;
    localparam int DEF_CTRL_W = 9;
    localparam int DEF_RD_W   = 5;

    // Control bundle layout: wb_sel[1:0], reg_we, mem_rw, mem_val, alu_sel[3:0]
    localparam int CTRL_WB_SEL    = 0;
    localparam int CTRL_WB_SEL_W  = 2;
    localparam int CTRL_REG_WE    = 2;
    localparam int CTRL_MEM_RW    = 3;
    localparam int CTRL_MEM_VAL   = 4;
    localparam int CTRL_ALU_SEL   = 5;
    localparam int CTRL_ALU_SEL_W = 4;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry {valid, ctrl, memread, data}. Clearing turns the entry
// into a bubble (valid and control dropped) while the payload is retained.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic              d_memread,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic              memread,
    output logic [DATA_W-1:0] data
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            ctrl    <= '0;
            memread <= 1'b0;
            // NOTE: the payload is reset too, so a never-written slot can
            // not leak X into the head when it is promoted.
            data    <= '0;
        end else if (clear) begin
            valid   <= 1'b0;
            ctrl    <= '0;
            memread <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            ctrl    <= d_ctrl;
            memread <= d_memread;
            data    <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with optional skid slot, flush-to-bubble,
// hazard taps and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int RD_W   = DEF_RD_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_memread,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RD_W-1:0]   haz_rd,
    output logic              haz_memread,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e state, state_nxt;
    logic   accept, pop;
    logic   head_load, head_clear, head_from_skid, skid_load, skid_clear;

    logic              head_valid, head_memread;
    logic [CTRL_W-1:0] head_ctrl;
    logic [DATA_W-1:0] head_data;
    logic              skid_valid, skid_memread;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign accept = in_valid & in_ready;
    assign pop    = head_valid & out_ready;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt      = state;
        head_load      = 1'b0;
        head_clear     = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            state_nxt  = ST_EMPTY;
            head_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: if (accept) begin
                    head_load = 1'b1;
                    state_nxt = ST_FULL;
                end
                ST_FULL: begin
                    if (pop && accept) begin
                        head_load = 1'b1;
                    end else if (pop) begin
                        head_clear = 1'b1;
                        state_nxt  = ST_EMPTY;
                    end else if (accept && SKID != 0) begin
                        skid_load = 1'b1;
                        state_nxt = ST_SKID;
                    end
                end
                ST_SKID: if (pop && skid_valid) begin
                    head_load      = 1'b1;
                    head_from_skid = 1'b1;
                    skid_clear     = 1'b1;
                    state_nxt      = ST_FULL;
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_nxt;
    end

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_head (
        .clk       (clk),
        .rst       (rst),
        .load      (head_load),
        .clear     (head_clear),
        .d_ctrl    (head_from_skid ? skid_ctrl    : in_ctrl),
        .d_memread (head_from_skid ? skid_memread : in_memread),
        .d_data    (head_from_skid ? skid_data    : in_data),
        .valid     (head_valid),
        .ctrl      (head_ctrl),
        .memread   (head_memread),
        .data      (head_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk       (clk),
                .rst       (rst),
                .load      (skid_load),
                .clear     (skid_clear),
                .d_ctrl    (in_ctrl),
                .d_memread (in_memread),
                .d_data    (in_data),
                .valid     (skid_valid),
                .ctrl      (skid_ctrl),
                .memread   (skid_memread),
                .data      (skid_data)
            );

            // Registered ready keeps out_ready off any path into in_ready.
            always_ff @(posedge clk) begin
                if (rst) in_ready_q <= 1'b1;
                else     in_ready_q <= (state_nxt != ST_SKID);
            end
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            logic unused_skid;
            assign unused_skid  = skid_load | skid_clear;
            assign skid_valid   = 1'b0;
            assign skid_ctrl    = '0;
            assign skid_memread = 1'b0;
            assign skid_data    = '0;
            assign in_ready     = (state == ST_EMPTY) | out_ready;
        end
    endgenerate

    assign out_valid   = head_valid;
    assign out_data    = head_data;
    assign out_ctrl    = head_valid ? head_ctrl : '0;
    assign haz_rd      = head_valid ? head_data[RD_W-1:0] : '0;
    assign haz_memread = head_valid & head_memread;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (head_valid && !out_ready && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid variant (CNT_W=4) and a single-entry variant
// share one stimulus stream; each is checked against a queue-based model.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW = DEF_DATA_W;
    localparam int CW = DEF_CTRL_W;
    localparam int RW = DEF_RD_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush, in_valid, out_ready, in_memread;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    logic          a_in_ready, a_out_valid, a_haz_memread;
    logic [DW-1:0] a_out_data;
    logic [CW-1:0] a_out_ctrl;
    logic [RW-1:0] a_haz_rd;
    logic [3:0]    a_stall_cnt;

    logic          b_in_ready, b_out_valid, b_haz_memread;
    logic [DW-1:0] b_out_data;
    logic [CW-1:0] b_out_ctrl;
    logic [RW-1:0] b_haz_rd;
    logic [15:0]   b_stall_cnt;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .RD_W(RW), .SKID(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .in_ctrl(in_ctrl), .in_memread(in_memread),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_ctrl(a_out_ctrl), .haz_rd(a_haz_rd), .haz_memread(a_haz_memread),
        .stall_cnt(a_stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .RD_W(RW), .SKID(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .in_ctrl(in_ctrl), .in_memread(in_memread),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_ctrl(b_out_ctrl), .haz_rd(b_haz_rd), .haz_memread(b_haz_memread),
        .stall_cnt(b_stall_cnt)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
        logic          mr;
    } ent_t;

    // Reference model: a FIFO of capacity 2 (a) or 1 (b).
    ent_t        qa[$];
    ent_t        qb[$];
    int unsigned cnt_a, cnt_b;
    logic        ready_a_m;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    function automatic logic [CW-1:0] load_ctrl();
        logic [CW-1:0] c;
        c = '0;
        c[CTRL_WB_SEL +: CTRL_WB_SEL_W]   = 2'd1;
        c[CTRL_REG_WE]                    = 1'b1;
        c[CTRL_MEM_VAL]                   = 1'b1;
        c[CTRL_MEM_RW]                    = 1'b0;
        c[CTRL_ALU_SEL +: CTRL_ALU_SEL_W] = 4'h3;
        return c;
    endfunction

    task automatic model_edge();
        ent_t e;
        bit   acc_a, acc_b, pop_a, pop_b;
        if (rst) begin
            qa.delete();
            qb.delete();
            cnt_a     = 0;
            cnt_b     = 0;
            ready_a_m = 1'b1;
        end else begin
            if (qa.size() > 0 && !out_ready && cnt_a < 15)    cnt_a++;
            if (qb.size() > 0 && !out_ready && cnt_b < 65535) cnt_b++;
            acc_a  = in_valid && ready_a_m;
            acc_b  = in_valid && (qb.size() == 0 || out_ready);
            pop_a  = qa.size() > 0 && out_ready;
            pop_b  = qb.size() > 0 && out_ready;
            e.data = in_data;
            e.ctrl = in_ctrl;
            e.mr   = in_memread;
            if (flush) qa.delete();
            else begin
                if (pop_a) void'(qa.pop_front());
                if (acc_a) qa.push_back(e);
            end
            if (flush) qb.delete();
            else begin
                if (pop_b) void'(qb.pop_front());
                if (acc_b) qb.push_back(e);
            end
            ready_a_m = qa.size() < 2;
        end
    endtask

    task automatic check_models();
        check("a_valid", a_out_valid, qa.size() > 0);
        check("a_ready", a_in_ready, ready_a_m);
        check("a_stall", a_stall_cnt, cnt_a);
        if (qa.size() > 0) begin
            check("a_data", a_out_data, qa[0].data);
            check("a_ctrl", a_out_ctrl, qa[0].ctrl);
            check("a_rd",   a_haz_rd,   qa[0].data[RW-1:0]);
            check("a_mr",   a_haz_memread, qa[0].mr);
        end else begin
            check("a_bubble_ctrl", a_out_ctrl, 0);
            check("a_bubble_rd",   a_haz_rd, 0);
            check("a_bubble_mr",   a_haz_memread, 0);
        end
        check("b_valid", b_out_valid, qb.size() > 0);
        check("b_ready", b_in_ready, qb.size() == 0 || out_ready);
        check("b_stall", b_stall_cnt, cnt_b);
        if (qb.size() > 0) begin
            check("b_data", b_out_data, qb[0].data);
            check("b_ctrl", b_out_ctrl, qb[0].ctrl);
            check("b_rd",   b_haz_rd,   qb[0].data[RW-1:0]);
            check("b_mr",   b_haz_memread, qb[0].mr);
        end else begin
            check("b_bubble_ctrl", b_out_ctrl, 0);
            check("b_bubble_rd",   b_haz_rd, 0);
            check("b_bubble_mr",   b_haz_memread, 0);
        end
    endtask

    // Inputs are driven just after a falling edge; outputs are checked 1ns after the rising edge.
    task automatic step(input logic r, input logic fl, input logic iv, input logic orr,
                        input logic [DW-1:0] d, input logic [CW-1:0] c, input logic m);
        rst        = r;
        flush      = fl;
        in_valid   = iv;
        out_ready  = orr;
        in_data    = d;
        in_ctrl    = c;
        in_memread = m;
        @(posedge clk);
        model_edge();
        #1;
        check_models();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic idle(input logic orr);
        step(1'b0, 1'b0, 1'b0, orr, '0, '0, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [CW-1:0] lc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0; in_memread = 1'b0;
        ready_a_m = 1'b1; cnt_a = 0; cnt_b = 0;
        lc = load_ctrl();
        @(negedge clk);

        // Reset state
        do_reset();
        check("rst_a_data",  a_out_data, 0);
        check("rst_b_data",  b_out_data, 0);
        check("rst_a_ready", a_in_ready, 1);

        // Streaming 1..8 at full throughput, one cycle latency
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, DW'(i), lc, 1'b0);
            check("stream_a", a_out_data, i);
            check("stream_b", b_out_data, i);
        end
        idle(1'b1);
        check("stream_a_stall", a_stall_cnt, 0);
        check("stream_b_stall", b_stall_cnt, 0);

        // Backpressure into the skid slot, then drain in order
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, DW'(32'hA), lc, 1'b0);
        check("bp_head_a", a_out_data, 32'hA);
        step(1'b0, 1'b0, 1'b1, 1'b0, DW'(32'hB), lc, 1'b0);
        check("bp_skid_ready", a_in_ready, 0);
        check("bp_head_hold", a_out_data, 32'hA);
        idle(1'b1);
        check("bp_second", a_out_data, 32'hB);
        check("bp_second_v", a_out_valid, 1);
        idle(1'b1);
        check("bp_drained", a_out_valid, 0);

        // Flush while in SKID with a simultaneous incoming transaction
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, DW'(32'hA), lc, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, DW'(32'hB), lc, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, DW'(32'hC), lc, 1'b1);
        check("fl_valid", a_out_valid, 0);
        check("fl_ctrl",  a_out_ctrl, 0);
        check("fl_mr",    a_haz_memread, 0);
        check("fl_ready", a_in_ready, 1);
        idle(1'b1);
        check("fl_no_c", a_out_valid, 0);

        // Load-use tap
        d = rnd_data();
        d[RW-1:0] = RW'(5);
        step(1'b0, 1'b0, 1'b1, 1'b0, d, lc, 1'b1);
        check("lu_rd_a", a_haz_rd, 5);
        check("lu_mr_a", a_haz_memread, 1);
        check("lu_rd_b", b_haz_rd, 5);
        idle(1'b1);
        check("lu_rd_clr", a_haz_rd, 0);
        check("lu_mr_clr", a_haz_memread, 0);

        // Stall counter saturation (4-bit on a, 16-bit on b)
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, rnd_data(), lc, 1'b0);
        repeat (20) idle(1'b0);
        check("sat_a", a_stall_cnt, 15);
        check("sat_b", b_stall_cnt, 20);
        do_reset();
        check("sat_a_rst", a_stall_cnt, 0);

        // Reset in mid-stall with an incoming transaction
        step(1'b0, 1'b0, 1'b1, 1'b0, DW'(32'hA), lc, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, DW'(32'hB), lc, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, DW'(32'hD), lc, 1'b1);
        check("rms_valid", a_out_valid, 0);
        check("rms_ready", a_in_ready, 1);
        check("rms_data",  a_out_data, 0);
        check("rms_mr",    a_haz_memread, 0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(63) == 0, $urandom_range(15) == 0,
                 $urandom_range(9) < 7, $urandom_range(9) < 6,
                 rnd_data(), CW'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
